ex_stage: RTL
=============

Name: ex_stage

Overview:
- Integer execute stage of the core. Sits between the decode stage (upstream, valid/ready) and the memory stage (downstream, valid/ready).
- Resolves operands by forwarding from its own output register and the writeback port.
- Drives the core's 4-bit-opcode combinational ALU and registers the result, destination and writeback enable into the EX/MEM pipeline register.
- Handles stall back-pressure, pipeline flush and a stall-cycle performance counter.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- SHAMT_MASK, 1, when 1, shift amount is masked to op2[4:0] for shift ops.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight EX/MEM entry and any same-cycle acceptance.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_alu_op  in  4  ALU opcode (encodings below).
- in_rs1, in_rs2  in  REGW  source register indices.
- in_rs1_val, in_rs2_val  in  XLEN  register-file read values.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  op2 = in_imm instead of rs2.
- in_rd  in  REGW  destination index.
- in_wb_en  in  1  instruction writes rd.
- wb_valid, wb_en  in  1 each  writeback stage carries a register write.
- wb_rd  in  REGW  writeback destination.
- wb_data  in  XLEN  writeback value.
- out_valid  out  1  EX/MEM entry valid.
- out_ready  in  1  memory stage accepts the entry.
- out_result  out  XLEN  registered ALU result.
- out_rd  out  REGW  registered destination.
- out_wb_en  out  1  registered writeback enable.
- stall_cnt  out  32  count of cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Reset (rstn=0, asynchronous): out_valid=0, out_result=0, out_rd=0, out_wb_en=0, stall_cnt=0.
- in_ready = !out_valid || out_ready. Combinational; does not depend on in_valid.
- Accept condition: in_valid && in_ready && !flush. On accept, EX/MEM loads result/rd/wb_en and out_valid=1 at the next edge. Latency is 1 cycle.
- out_valid && out_ready && no accept: out_valid=0 next edge. Data fields hold their last value.
- out_valid && !out_ready: all EX/MEM fields hold, and stall_cnt increments unless saturated.
- flush=1: out_valid=0 next edge regardless of out_ready or in_valid. flush does not clear stall_cnt. in_ready is not gated by flush.
- Operand forwarding (per source, rs1 shown; rs2 identical):
  - Priority 1: out_valid && out_wb_en && out_rd==in_rs1 && in_rs1!=0 → out_result.
  - Priority 2: wb_valid && wb_en && wb_rd==in_rs1 && in_rs1!=0 → wb_data.
  - Otherwise in_rs1_val. Index 0 is never forwarded.
- op1 = forwarded rs1. op2 = in_use_imm ? in_imm : forwarded rs2.
- ALU opcodes:
  - 0000 sll, 0001 srl, 0010 sra, 0011 add, 0100 sub, 0101 and, 0110 or, 0111 xor.
  - 1000 signed slt, 1001 eq, 1010 ne. Compare results are zero-extended 0/1.
  - Other encodings yield 0.
- When SHAMT_MASK=1, op2 for 0000/0001/0010 is {27'b0, op2[4:0]} before the ALU.
- Add/sub wrap modulo 2^XLEN. No overflow flag.
- Simultaneous drain and accept (out_valid && out_ready && accept): new entry loads, out_valid stays 1. No bubble.
- Forwarding uses the EX/MEM register contents present in the accept cycle, including an entry being drained that same cycle.
- Reset asserted mid-stall: entry discarded; counter zeroed.

Decomposition:
- core_pkg holds:
  - alu_op_t enum, 4-bit, with the 11 encodings above.
  - XLEN/REGW localparams.
  - ALU_SHIFT_OPS constant set.
- Sub-module ex_fwd_mux: one instance per source operand. Inputs: index, rf value, EX/MEM tuple, WB tuple. Output: the forwarded value.
- The core ALU is instantiated unchanged.

Test Plan:
- Reset, then in: add, rs1_val=5, rs2_val=7, rd=3, wb_en=1, out_ready=1 → next cycle out_valid=1, out_result=12, out_rd=3.
- Back-to-back dependency: add rd=3 result 12, then sub rs1=3 (rf value stale 0), rs2_val=2 → out_result=10 (EX/MEM forward). Same case with both EX/MEM and WB matching rd=3 (wb_data=99) → EX/MEM value 12 wins.
- rs1=0 with wb_rd=0, wb_data=55, rs1_val=0, add imm 4 → out_result=4. x0 is never forwarded.
- out_ready=0 for 3 cycles with entry valid → in_ready=0, outputs frozen, stall_cnt=3. flush on cycle 4 → out_valid=0 next cycle, stall_cnt stays 3.
- Shifts: sra op1=0x80000000, op2=33 → 0xC0000000 (masked to 1). slt op1=0xFFFFFFFF, op2=1 → 1. Opcode 1111 → 0.
- rstn pulled low asynchronously between edges while out_valid=1 → out_valid=0 immediately, before next clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath sizes and the ALU opcode map.
package core_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_SLL = 4'b0000,
        ALU_SRL = 4'b0001,
        ALU_SRA = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_AND = 4'b0101,
        ALU_OR  = 4'b0110,
        ALU_XOR = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_EQ  = 4'b1001,
        ALU_NE  = 4'b1010
    } alu_op_t;

    // Bit n set means opcode n is a shift.
    localparam logic [15:0] ALU_SHIFT_OPS = 16'h0007;

endpackage

// File: rtl/core_alu.sv
// Core combinational ALU, 4-bit opcode.
module core_alu
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_SLL: y = a << b;
            ALU_SRL: y = a >> b;
            ALU_SRA: y = $signed(a) >>> b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_EQ:  y = {{(XLEN-1){1'b0}}, a == b};
            ALU_NE:  y = {{(XLEN-1){1'b0}}, a != b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ex_fwd_mux.sv
// Operand forwarding: EX/MEM result beats writeback, x0 never forwarded.
module ex_fwd_mux #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] idx,
    input  logic [XLEN-1:0] rf_val,
    input  logic            ex_valid,
    input  logic            ex_wb_en,
    input  logic [REGW-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_valid,
    input  logic            wb_en,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);

    always_comb begin
        val = rf_val;
        if (idx != '0) begin
            if (ex_valid && ex_wb_en && ex_rd == idx)
                val = ex_data;
            else if (wb_valid && wb_en && wb_rd == idx)
                val = wb_data;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Integer execute stage: forwarding, ALU and the EX/MEM pipeline register.
module ex_stage
    import core_pkg::*;
#(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int REGW       = core_pkg::REGW,
    parameter int SHAMT_MASK = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_op,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_wb_en,
    input  logic            wb_valid,
    input  logic            wb_en,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_wb_en,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op2_alu;
    logic [XLEN-1:0] alu_y;
    logic            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    ex_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd1 (
        .idx      (in_rs1),
        .rf_val   (in_rs1_val),
        .ex_valid (out_valid),
        .ex_wb_en (out_wb_en),
        .ex_rd    (out_rd),
        .ex_data  (out_result),
        .wb_valid (wb_valid),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (op1)
    );

    ex_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd2 (
        .idx      (in_rs2),
        .rf_val   (in_rs2_val),
        .ex_valid (out_valid),
        .ex_wb_en (out_wb_en),
        .ex_rd    (out_rd),
        .ex_data  (out_result),
        .wb_valid (wb_valid),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (rs2_fwd)
    );

    assign op2 = in_use_imm ? in_imm : rs2_fwd;

    always_comb begin
        op2_alu = op2;
        if (SHAMT_MASK != 0 && ALU_SHIFT_OPS[in_alu_op])
            op2_alu = {{(XLEN-5){1'b0}}, op2[4:0]};
    end

    core_alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op_t'(in_alu_op)),
        .a  (op1),
        .b  (op2_alu),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wb_en  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_result <= alu_y;
                out_rd     <= in_rd;
                out_wb_en  <= in_wb_en;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Counts stalled cycles even when a flush is also present.
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
